shift_exec_stage: RTL and testbench

- Two-stage pipelined execute slice for RV32I shift instructions (SLL, SRL, SRA, SLLI, SRLI, SRAI).
- Decodes the instruction and selects the shift amount from rs2 or the immediate.
- Drives the combinational shifter from a registered operand stage, then registers the result toward writeback.
- Valid/ready handshake on both sides, plus a synchronous flush for branch redirect.

---
 rtl/shift_pkg.sv | 20 ++
 rtl/shift_exec_stage_shifter.sv | 25 ++
 rtl/shift_exec_stage.sv | 129 ++++++++++++
 tb/tb_shift_exec_stage.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared decode constants and shift-type encoding for the RV32I shift execute slice.
package shift_pkg;

    typedef enum logic [1:0] {
        SH_LL   = 2'd0,
        SH_RL   = 2'd1,
        SH_RA   = 2'd2,
        SH_PASS = 2'd3
    } shift_type_e;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_SR  = 3'b101;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

endpackage

// File: rtl/shift_exec_stage_shifter.sv
// Combinational barrel shifter: left, logical right, arithmetic right or pass-through.
module shift_exec_stage_shifter
    import shift_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = 5
) (
    input  logic [XLEN-1:0]    val,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [1:0]         shift_type,
    output logic [XLEN-1:0]    shifted_val
);

    always_comb begin
        // NOTE: a default assignment up front keeps this block free of inferred latches.
        shifted_val = val;
        case (shift_type)
            SH_LL:   shifted_val = val << shamt;
            SH_RL:   shifted_val = val >> shamt;
            SH_RA:   shifted_val = $signed(val) >>> shamt;
            default: shifted_val = val;
        endcase
    end

endmodule

// File: rtl/shift_exec_stage.sv
// Two-stage execute slice for RV32I shifts: decode into an operand register (S1),
// shift, then register the result (S2) toward writeback with valid/ready on both sides.
module shift_exec_stage
    import shift_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = 5
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic [4:0]      out_rd,
    output logic            out_illegal
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];

    shift_type_e        dec_type;
    logic [SHAMT_W-1:0] dec_shamt;
    logic               dec_illegal;

    always_comb begin
        dec_type    = SH_PASS;
        dec_shamt   = '0;
        dec_illegal = 1'b1;
        if (opcode == OPC_OP_IMM) begin
            dec_shamt = instr[20 +: SHAMT_W];
        end else if (opcode == OPC_OP) begin
            dec_shamt = rs2_val[SHAMT_W-1:0];
        end
        if (opcode == OPC_OP_IMM || opcode == OPC_OP) begin
            if (funct3 == F3_SLL && funct7 == F7_BASE) begin
                dec_type    = SH_LL;
                dec_illegal = 1'b0;
            end else if (funct3 == F3_SR && funct7 == F7_BASE) begin
                dec_type    = SH_RL;
                dec_illegal = 1'b0;
            end else if (funct3 == F3_SR && funct7 == F7_ALT) begin
                dec_type    = SH_RA;
                dec_illegal = 1'b0;
            end
        end
    end

    // rs1 index and upper rs2 bits play no part in a shift.
    logic unused_bits;
    assign unused_bits = ^{instr[19:15], rs2_val[XLEN-1:SHAMT_W]};

    logic s1_valid;
    logic s2_valid;
    logic s1_accept;
    logic s2_accept;

    assign s2_accept = !s2_valid || out_ready;
    assign s1_accept = !s1_valid || s2_accept;
    assign in_ready  = s1_accept && reset_n;
    assign out_valid = s2_valid;

    logic [XLEN-1:0]    s1_val;
    logic [SHAMT_W-1:0] s1_shamt;
    shift_type_e        s1_type;
    logic [4:0]         s1_rd;
    logic               s1_illegal;

    always_ff @(posedge clk) begin
        // NOTE: operand registers have no reset; s1_valid alone says whether they hold anything.
        if (in_valid && in_ready) begin
            s1_val     <= rs1_val;
            s1_shamt   <= dec_shamt;
            s1_type    <= dec_type;
            s1_rd      <= instr[11:7];
            s1_illegal <= dec_illegal;
        end
    end

    logic [XLEN-1:0] shifted_val;

    shift_exec_stage_shifter #(
        .XLEN    (XLEN),
        .SHAMT_W (SHAMT_W)
    ) u_shifter (
        .val         (s1_val),
        .shamt       (s1_shamt),
        .shift_type  (s1_type),
        .shifted_val (shifted_val)
    );

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register here sees the pre-edge
        // valid bits, which is what lets S2 drain and S1 advance in the same cycle.
        if (!reset_n) begin
            s1_valid    <= 1'b0;
            s2_valid    <= 1'b0;
            out_result  <= '0;
            out_rd      <= '0;
            out_illegal <= 1'b0;
        end else if (flush) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            if (s2_accept) begin
                s2_valid <= s1_valid;
            end
            if (s1_accept) begin
                s1_valid <= in_valid;
            end
            if (s1_valid && s2_accept) begin
                out_result  <= shifted_val;
                out_rd      <= s1_rd;
                out_illegal <= s1_illegal;
            end
        end
    end

endmodule

// File: tb/tb_shift_exec_stage.sv
// Self-checking bench for shift_exec_stage: directed literal cases plus randomized
// traffic compared every cycle against a transaction-level FIFO model.
module tb_shift_exec_stage;

    logic        clk;
    logic        reset_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_rd;
    logic        out_illegal;

    shift_exec_stage dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .instr       (instr),
        .rs1_val     (rs1_val),
        .rs2_val     (rs2_val),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_rd      (out_rd),
        .out_illegal (out_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        logic        ill;
        bit          shown;
    } ent_t;

    function automatic ent_t ref_exec(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
        ent_t e;
        int   sh;
        logic [6:0] opc = ins[6:0];
        logic [2:0] f3  = ins[14:12];
        logic [6:0] f7  = ins[31:25];
        e.rd    = ins[11:7];
        e.shown = 1'b0;
        e.ill   = 1'b1;
        e.res   = a;
        if (opc == 7'h13 || opc == 7'h33) begin
            sh = (opc == 7'h13) ? int'(ins[24:20]) : int'(b[4:0]);
            if (f3 == 3'd1 && f7 == 7'h00) begin
                e.ill = 1'b0;
                e.res = a << sh;
            end else if (f3 == 3'd5 && f7 == 7'h00) begin
                e.ill = 1'b0;
                e.res = a >> sh;
            end else if (f3 == 3'd5 && f7 == 7'h20) begin
                e.ill = 1'b0;
                e.res = (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
            end
        end
        return e;
    endfunction

    // In-flight transactions, oldest first; at most two. 'shown' marks the one
    // currently presented at the output.
    ent_t q[$];
    bit   model_on = 1'b0;
    bit   m_acc;
    ent_t m_tmp;

    always @(posedge clk) begin
        m_acc = in_valid && reset_n && (q.size() < 2 || out_ready);
        if (!reset_n) begin
            q.delete();
            model_on = 1'b1;
        end else if (flush) begin
            q.delete();
        end else begin
            if (q.size() > 0 && q[0].shown && out_ready) begin
                void'(q.pop_front());
            end
            if (q.size() > 0 && !q[0].shown) begin
                m_tmp       = q[0];
                m_tmp.shown = 1'b1;
                q[0]        = m_tmp;
            end
            if (m_acc) begin
                q.push_back(ref_exec(instr, rs1_val, rs2_val));
            end
        end
    end

    always @(negedge clk) begin
        if (model_on) begin
            check("m_in_ready", in_ready, reset_n && (q.size() < 2 || out_ready));
            check("m_out_valid", out_valid, q.size() > 0 && q[0].shown);
            if (q.size() > 0 && q[0].shown) begin
                check("m_out_result", out_result, q[0].res);
                check("m_out_rd", out_rd, q[0].rd);
                check("m_out_illegal", out_illegal, q[0].ill);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic v, input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
        in_valid = v;
        instr    = ins;
        rs1_val  = a;
        rs2_val  = b;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0] opc;
        logic [2:0] f3;
        logic [6:0] f7;
        int         kind;
        kind = int'($urandom_range(0, 7));
        opc  = ($urandom_range(0, 1) == 0) ? 7'h13 : 7'h33;
        f3   = 3'd1;
        f7   = 7'h00;
        if (kind < 6) begin
            case (kind % 3)
                0: begin f3 = 3'd1; f7 = 7'h00; end
                1: begin f3 = 3'd5; f7 = 7'h00; end
                default: begin f3 = 3'd5; f7 = 7'h20; end
            endcase
        end else if (kind == 6) begin
            f3 = 3'($urandom_range(0, 7));
            f7 = 7'($urandom);
        end else begin
            return $urandom;
        end
        return {f7, 5'($urandom), 5'($urandom), f3, 5'($urandom), opc};
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n   = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        set_in(1'b0, 32'h0, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_result", out_result, 0);
        check("rst_out_rd", out_rd, 0);
        check("rst_out_illegal", out_illegal, 0);
        check("rst_in_ready_low", in_ready, 0);
        reset_n = 1'b1;
        #1;
        check("rst_in_ready_high", in_ready, 1);

        // SLLI x1,x1,2 on 21
        set_in(1'b1, 32'h0020_9093, 32'd21, 32'h0);
        step();
        in_valid = 1'b0;
        step();
        check("slli_valid", out_valid, 1);
        check("slli_result", out_result, 32'd84);
        check("slli_rd", out_rd, 5'd1);
        check("slli_illegal", out_illegal, 0);
        step();

        // SRAI then SRL back to back
        set_in(1'b1, 32'h4020_D113, 32'hFFFF_FFEB, 32'h0);
        step();
        set_in(1'b1, 32'h0020_D1B3, 32'hFFFF_FFEB, 32'h22);
        step();
        in_valid = 1'b0;
        check("srai_result", out_result, 32'hFFFF_FFFA);
        check("srai_rd", out_rd, 5'd2);
        step();
        check("srl_result", out_result, 32'h3FFF_FFFA);
        check("srl_rd", out_rd, 5'd3);
        step();

        // Back-pressure: three SLLI by 2 with out_ready low
        out_ready = 1'b0;
        set_in(1'b1, 32'h0020_9093, 32'd1, 32'h0);
        step();
        set_in(1'b1, 32'h0020_9093, 32'd2, 32'h0);
        step();
        set_in(1'b1, 32'h0020_9093, 32'd3, 32'h0);
        check("bp_in_ready_full", in_ready, 0);
        check("bp_hold_0", out_result, 32'd4);
        step();
        check("bp_hold_1", out_result, 32'd4);
        check("bp_valid_1", out_valid, 1);
        step();
        check("bp_hold_2", out_result, 32'd4);
        check("bp_in_ready_still", in_ready, 0);
        out_ready = 1'b1;
        #1;
        check("bp_in_ready_release", in_ready, 1);
        step();
        in_valid = 1'b0;
        check("bp_drain_2", out_result, 32'd8);
        step();
        check("bp_drain_3", out_result, 32'd12);
        check("bp_drain_3_valid", out_valid, 1);
        step();
        check("bp_empty", out_valid, 0);

        // Illegal encodings
        set_in(1'b1, 32'h4020_9093, 32'h1234_5678, 32'h0);
        step();
        set_in(1'b1, 32'h1234_50B7, 32'hCAFE_F00D, 32'h0);
        step();
        in_valid = 1'b0;
        check("ill_f7_flag", out_illegal, 1);
        check("ill_f7_result", out_result, 32'h1234_5678);
        check("ill_f7_rd", out_rd, 5'd1);
        step();
        check("ill_lui_flag", out_illegal, 1);
        check("ill_lui_result", out_result, 32'hCAFE_F00D);
        step();

        // Flush with two in flight and a fresh offer during flush
        set_in(1'b1, 32'h0020_9093, 32'd5, 32'h0);
        step();
        set_in(1'b1, 32'h0020_9093, 32'd6, 32'h0);
        step();
        flush = 1'b1;
        set_in(1'b1, 32'h0020_9093, 32'd7, 32'h0);
        step();
        flush = 1'b0;
        check("flush_out_valid", out_valid, 0);
        set_in(1'b1, 32'h0040_D293, 32'h8000_0000, 32'h0);
        step();
        in_valid = 1'b0;
        check("flush_dropped", out_valid, 0);
        step();
        check("flush_next_valid", out_valid, 1);
        check("flush_next_result", out_result, 32'h0800_0000);
        check("flush_next_rd", out_rd, 5'd5);
        step();

        // Reset with both stages full and output stalled
        out_ready = 1'b0;
        set_in(1'b1, 32'h0020_9093, 32'd9, 32'h0);
        step();
        set_in(1'b1, 32'h0020_9093, 32'd10, 32'h0);
        step();
        in_valid = 1'b0;
        reset_n  = 1'b0;
        #1;
        check("mid_rst_in_ready", in_ready, 0);
        step();
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_result", out_result, 0);
        check("mid_rst_rd", out_rd, 0);
        check("mid_rst_illegal", out_illegal, 0);
        reset_n = 1'b1;
        #1;
        check("mid_rst_in_ready_after", in_ready, 1);
        out_ready = 1'b1;
        set_in(1'b1, 32'h0020_9233, 32'd1, 32'd31);
        step();
        in_valid = 1'b0;
        step();
        check("sll31_result", out_result, 32'h8000_0000);
        check("sll31_rd", out_rd, 5'd4);
        step();

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            reset_n   = ($urandom_range(0, 199) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            out_ready = ($urandom_range(0, 2) != 0);
            set_in($urandom_range(0, 3) != 0, rand_instr(), $urandom, $urandom);
            step();
        end

        reset_n   = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b1;
        in_valid  = 1'b0;
        repeat (4) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
